// File: rtl/serial_adder.sv
// Bit-serial adder: one full-adder cell, LSB first, valid/ready on both sides.
// Optional subtract mode enabled by defining SERIAL_ADDER_SUB_EN (adds port in_sub).
module serial_adder #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             in_c,
`ifdef SERIAL_ADDER_SUB_EN
  input  logic             in_sub,
`endif
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_sum,
  output logic             out_carry,
  output logic             busy
);

  localparam int unsigned CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_e;

  state_e             state_q, state_d;
  logic [WIDTH-1:0]   a_q, a_d;
  logic [WIDTH-1:0]   b_q, b_d;
  logic [WIDTH-2:0]   acc_q, acc_d;
  logic               carry_q, carry_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [WIDTH-1:0]   out_sum_q, out_sum_d;
  logic               out_carry_q, out_carry_d;

  logic               fa_sum;
  logic               fa_carry;
  logic [WIDTH-1:0]   acc_shift;

  // Single full-adder cell on the current LSBs.
  always_comb begin
    fa_sum    = a_q[0] ^ b_q[0] ^ carry_q;
    fa_carry  = (a_q[0] & b_q[0]) | (a_q[0] & carry_q) | (b_q[0] & carry_q);
    // Result register holds WIDTH-1 bits; the final sum bit joins on the last edge.
    acc_shift = {fa_sum, acc_q};
  end

  always_comb begin
    state_d     = state_q;
    a_d         = a_q;
    b_d         = b_q;
    acc_d       = acc_q;
    carry_d     = carry_q;
    cnt_d       = cnt_q;
    out_sum_d   = out_sum_q;
    out_carry_d = out_carry_q;

    case (state_q)
      IDLE: begin
        if (in_valid) begin
          a_d     = in_a;
          b_d     = in_b;
          carry_d = in_c;
`ifdef SERIAL_ADDER_SUB_EN
          // Subtract as a + ~b + 1; carry-out of 1 then means no borrow.
          if (in_sub) begin
            b_d     = ~in_b;
            carry_d = 1'b1;
          end
`endif
          cnt_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        a_d     = a_q >> 1;
        b_d     = b_q >> 1;
        acc_d   = acc_shift[WIDTH-1:1];
        carry_d = fa_carry;
        cnt_d   = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(WIDTH - 1)) begin
          out_sum_d   = acc_shift;
          out_carry_d = fa_carry;
          state_d     = DONE;
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      a_q         <= '0;
      b_q         <= '0;
      acc_q       <= '0;
      carry_q     <= 1'b0;
      cnt_q       <= '0;
      out_sum_q   <= '0;
      out_carry_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      a_q         <= a_d;
      b_q         <= b_d;
      acc_q       <= acc_d;
      carry_q     <= carry_d;
      cnt_q       <= cnt_d;
      out_sum_q   <= out_sum_d;
      out_carry_q <= out_carry_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign busy      = (state_q == RUN) || (state_q == DONE);
  assign out_sum   = out_sum_q;
  assign out_carry = out_carry_q;

endmodule

// File: tb/tb_serial_adder.sv
// Directed bench for serial_adder (WIDTH=8); define SERIAL_ADDER_SUB_EN to cover subtract mode.
module tb_serial_adder;

  localparam int unsigned WIDTH = 8;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_a;
  logic [WIDTH-1:0] in_b;
  logic             in_c;
`ifdef SERIAL_ADDER_SUB_EN
  logic             in_sub;
`endif
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_sum;
  logic             out_carry;
  logic             busy;

  int unsigned n_tests = 0;
  int unsigned n_fail  = 0;

  serial_adder #(.WIDTH(WIDTH)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_b      (in_b),
    .in_c      (in_c),
`ifdef SERIAL_ADDER_SUB_EN
    .in_sub    (in_sub),
`endif
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_sum   (out_sum),
    .out_carry (out_carry),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Called #1 after the accepting edge; counts edges until out_valid.
  task automatic wait_result(input string tag, input logic [7:0] es, input logic ec);
    int unsigned n = 0;
    while (!out_valid && n < 40) begin
      @(posedge clk);
      #1;
      n++;
    end
    check({tag, " latency"}, n, WIDTH);
    check({tag, " sum"}, {24'd0, out_sum}, {24'd0, es});
    check({tag, " carry"}, {31'd0, out_carry}, {31'd0, ec});
    check({tag, " in_ready in DONE"}, {31'd0, in_ready}, 32'd0);
  endtask

  task automatic run_op(input string tag, input logic [7:0] a, input logic [7:0] b,
                        input logic c, input logic [7:0] es, input logic ec);
    @(negedge clk);
    check({tag, " in_ready idle"}, {31'd0, in_ready}, 32'd1);
    in_a     = a;
    in_b     = b;
    in_c     = c;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    check({tag, " busy"}, {31'd0, busy}, 32'd1);
    wait_result(tag, es, ec);
  endtask

  task automatic drain(input string tag);
    @(posedge clk);
    #1;
    check({tag, " out_valid drop"}, {31'd0, out_valid}, 32'd0);
    check({tag, " in_ready back"}, {31'd0, in_ready}, 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int unsigned n;
    bit          seen;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_a      = '0;
    in_b      = '0;
    in_c      = 1'b0;
    out_ready = 1'b1;
`ifdef SERIAL_ADDER_SUB_EN
    in_sub    = 1'b0;
`endif
    repeat (2) @(posedge clk);
    #1;
    check("rst in_ready", {31'd0, in_ready}, 32'd1);
    check("rst out_valid", {31'd0, out_valid}, 32'd0);
    check("rst busy", {31'd0, busy}, 32'd0);
    check("rst out_sum", {24'd0, out_sum}, 32'd0);
    check("rst out_carry", {31'd0, out_carry}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Basic add.
    run_op("add5a3c", 8'h5A, 8'h3C, 1'b0, 8'h96, 1'b0);
    drain("add5a3c");
    check("hold in IDLE", {24'd0, out_sum}, 32'h96);

    // Stall in DONE while new operands are offered.
    out_ready = 1'b0;
    run_op("stall", 8'h5A, 8'h3C, 1'b0, 8'h96, 1'b0);
    in_valid = 1'b1;
    in_a     = 8'h11;
    in_b     = 8'h22;
    in_c     = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("stall out_valid", {31'd0, out_valid}, 32'd1);
      check("stall in_ready", {31'd0, in_ready}, 32'd0);
      check("stall sum", {24'd0, out_sum}, 32'h96);
      check("stall carry", {31'd0, out_carry}, 32'd0);
    end
    @(negedge clk);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    drain("stall");
    check("stall sum after take", {24'd0, out_sum}, 32'h96);

    // Back-to-back: second accept 10 edges after the first.
    @(negedge clk);
    in_a     = 8'hFF;
    in_b     = 8'h01;
    in_c     = 1'b0;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_b = 8'hFF;
    in_c = 1'b1;
    n    = 1;
    seen = 1'b0;
    while (n < 40) begin
      @(negedge clk);
      if (out_valid && !seen) begin
        seen = 1'b1;
        check("b2b first sum", {24'd0, out_sum}, 32'h00);
        check("b2b first carry", {31'd0, out_carry}, 32'd1);
      end
      if (in_ready) begin
        @(posedge clk);
        break;
      end
      @(posedge clk);
      n++;
    end
    #1;
    in_valid = 1'b0;
    check("b2b spacing", n, WIDTH + 2);
    check("b2b first seen", {31'd0, seen}, 32'd1);
    wait_result("b2b second", 8'hFF, 1'b1);
    drain("b2b second");

    // Reset during the 3rd RUN cycle.
    @(negedge clk);
    in_a     = 8'hAA;
    in_b     = 8'h55;
    in_c     = 1'b0;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("abort out_valid", {31'd0, out_valid}, 32'd0);
    check("abort in_ready", {31'd0, in_ready}, 32'd1);
    check("abort busy", {31'd0, busy}, 32'd0);
    check("abort sum", {24'd0, out_sum}, 32'd0);
    check("abort carry", {31'd0, out_carry}, 32'd0);
    in_a     = 8'h01;
    in_b     = 8'h01;
    in_valid = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    check("first accept after reset", {31'd0, busy}, 32'd1);
    wait_result("post reset", 8'h02, 1'b0);
    drain("post reset");

    // Carry-chain corners.
    run_op("add8080", 8'h80, 8'h80, 1'b0, 8'h00, 1'b1);
    drain("add8080");
    run_op("add7f00c", 8'h7F, 8'h00, 1'b1, 8'h80, 1'b0);
    drain("add7f00c");

`ifdef SERIAL_ADDER_SUB_EN
    in_sub = 1'b1;
    run_op("sub10m01", 8'h10, 8'h01, 1'b1, 8'h0F, 1'b1);
    drain("sub10m01");
    run_op("sub01m02", 8'h01, 8'h02, 1'b1, 8'hFF, 1'b0);
    drain("sub01m02");
    in_sub = 1'b0;
    run_op("add after sub", 8'h10, 8'h01, 1'b1, 8'h12, 1'b0);
    drain("add after sub");
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
